// File: rtl/prach_reshape_pkg.sv
// -----------------------------------------------------------------------------
// prach_reshape_pkg
// Shared types and helpers for the PRACH reshape block.
//   mode_e      : active pairing mode (BYPASS passes beats through, PAIR joins
//                 the even and odd beat of each TDM channel into one output)
//   chn_w()     : width of a channel index for a given channel count (min 1)
//   CHN_FIELD_W : width of the external channel-index field
// -----------------------------------------------------------------------------
package prach_reshape_pkg;

   typedef enum logic {
      MODE_BYPASS = 1'b0,
      MODE_PAIR   = 1'b1
   } mode_e;

   localparam int CHN_FIELD_W = 8;

   function automatic int chn_w(input int num_chn);
      return (num_chn > 1) ? $clog2(num_chn) : 1;
   endfunction

endpackage

// File: rtl/prach_reshape2_if.sv
// -----------------------------------------------------------------------------
// prach_reshape2_if
// Sample stream in / paired stream out of the PRACH reshape block.
//   din_valid, din_dr, din_di, din_chn, sync_in       : input beat
//   dout_valid, dout_p1_*, dout_p2_*, dout_chn, sync_out : output beat
// master drives the input beat and observes the output; slave is the block.
// -----------------------------------------------------------------------------
interface prach_reshape2_if #(
   parameter int NUM_LANE = 3,
   parameter int WIDTH    = 16
);
   logic                           din_valid;
   logic [NUM_LANE-1:0][WIDTH-1:0] din_dr;
   logic [NUM_LANE-1:0][WIDTH-1:0] din_di;
   logic [7:0]                     din_chn;
   logic                           sync_in;

   logic                           dout_valid;
   logic [NUM_LANE-1:0][WIDTH-1:0] dout_p1_dr;
   logic [NUM_LANE-1:0][WIDTH-1:0] dout_p1_di;
   logic [NUM_LANE-1:0][WIDTH-1:0] dout_p2_dr;
   logic [NUM_LANE-1:0][WIDTH-1:0] dout_p2_di;
   logic [7:0]                     dout_chn;
   logic                           sync_out;

   modport master (
      output din_valid, din_dr, din_di, din_chn, sync_in,
      input  dout_valid, dout_p1_dr, dout_p1_di, dout_p2_dr, dout_p2_di,
             dout_chn, sync_out
   );

   modport slave (
      input  din_valid, din_dr, din_di, din_chn, sync_in,
      output dout_valid, dout_p1_dr, dout_p1_di, dout_p2_dr, dout_p2_di,
             dout_chn, sync_out
   );
endinterface

// File: rtl/prach_reshape2_lane.sv
// -----------------------------------------------------------------------------
// prach_reshape2_lane
// One sample lane: per-channel buffer of the pending even sample plus the two
// pipeline register stages for the phase-1 / phase-2 output.
//   clk, rst_n      : clock, synchronous active-low reset
//   buf_wr          : store din into buffer[chn_idx] (even beat in PAIR mode)
//   pair_rd         : this beat is odd: p1 = buffer[chn_idx], p2 = din
//   beat_load       : accepted beat that will produce an output
//   out_load        : stage-1 content moves to the output registers
//   chn_idx         : channel of the current beat
//   din_dr, din_di  : lane input sample
//   p1_*, p2_*      : lane output sample, held while not loaded
// -----------------------------------------------------------------------------
module prach_reshape2_lane #(
   parameter int WIDTH   = 16,
   parameter int NUM_CHN = 8,
   parameter int CHN_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             buf_wr,
   input  logic             pair_rd,
   input  logic             beat_load,
   input  logic             out_load,
   input  logic [CHN_W-1:0] chn_idx,
   input  logic [WIDTH-1:0] din_dr,
   input  logic [WIDTH-1:0] din_di,
   output logic [WIDTH-1:0] p1_dr,
   output logic [WIDTH-1:0] p1_di,
   output logic [WIDTH-1:0] p2_dr,
   output logic [WIDTH-1:0] p2_di
);

   logic [WIDTH-1:0] buf_dr [NUM_CHN];
   logic [WIDTH-1:0] buf_di [NUM_CHN];
   logic [WIDTH-1:0] s1_p1_dr, s1_p1_di, s1_p2_dr, s1_p2_di;

   // Buffer is not reset: the parity vector decides whether an entry is live.
   always_ff @(posedge clk) begin
      if (buf_wr) begin
         buf_dr[chn_idx] <= din_dr;
         buf_di[chn_idx] <= din_di;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_p1_dr <= '0;
         s1_p1_di <= '0;
         s1_p2_dr <= '0;
         s1_p2_di <= '0;
      end else if (beat_load) begin
         s1_p1_dr <= pair_rd ? buf_dr[chn_idx] : din_dr;
         s1_p1_di <= pair_rd ? buf_di[chn_idx] : din_di;
         s1_p2_dr <= pair_rd ? din_dr : '0;
         s1_p2_di <= pair_rd ? din_di : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p1_dr <= '0;
         p1_di <= '0;
         p2_dr <= '0;
         p2_di <= '0;
      end else if (out_load) begin
         p1_dr <= s1_p1_dr;
         p1_di <= s1_p1_di;
         p2_dr <= s1_p2_dr;
         p2_di <= s1_p2_di;
      end
   end

endmodule

// File: rtl/prach_reshape2.sv
// -----------------------------------------------------------------------------
// prach_reshape2
// Reshapes a TDM multi-lane complex sample stream. In BYPASS each beat is
// passed through (p2 = 0); in PAIR the even and odd beat of every channel are
// joined into one output beat (p1 = even, p2 = odd). Fixed 2-cycle latency,
// one beat per cycle, no backpressure.
//   clk, rst_n : clock, synchronous active-low reset
//   cfg_mode   : requested mode, taken over only on a sync beat
//   bus        : input / output beat (prach_reshape2_if.slave)
//   err_chn    : sticky, a beat arrived with an out-of-range channel
// -----------------------------------------------------------------------------
module prach_reshape2
   import prach_reshape_pkg::*;
#(
   parameter int NUM_LANE = 3,
   parameter int WIDTH    = 16,
   parameter int NUM_CHN  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_mode,
   prach_reshape2_if.slave bus,
   output logic            err_chn
);

   localparam int CHN_W = chn_w(NUM_CHN);
   localparam logic [CHN_FIELD_W-1:0] NUM_CHN_F = CHN_FIELD_W'(NUM_CHN);

   mode_e                  mode_q, mode_eff;
   logic [NUM_CHN-1:0]     parity_q, parity_d;
   logic                   armed_q, armed_d;
   logic                   sync_now, chn_ok, accept, par_eff;
   logic                   emit, buf_wr, pair_rd;
   logic [CHN_W-1:0]       chn_idx;
   logic                   s1_emit_q, s1_sync_q;
   logic [CHN_FIELD_W-1:0] s1_chn_q;

   logic [NUM_LANE-1:0][WIDTH-1:0] p1_dr, p1_di, p2_dr, p2_di;

   // A sync beat is processed with cleared parity and the freshly requested
   // mode, so an odd-parity channel's pending even sample is dropped here.
   always_comb begin
      sync_now = bus.din_valid && bus.sync_in;
      chn_ok   = bus.din_chn < NUM_CHN_F;
      accept   = bus.din_valid && chn_ok;
      chn_idx  = bus.din_chn[CHN_W-1:0];
      mode_eff = sync_now ? mode_e'(cfg_mode) : mode_q;
      par_eff  = sync_now ? 1'b0 : parity_q[chn_idx];
      pair_rd  = accept && (mode_eff == MODE_PAIR) && par_eff;
      buf_wr   = accept && (mode_eff == MODE_PAIR) && !par_eff;
      emit     = accept && ((mode_eff == MODE_BYPASS) || par_eff);

      parity_d = sync_now ? '0 : parity_q;
      if (accept && (mode_eff == MODE_PAIR)) begin
         parity_d[chn_idx] = ~par_eff;
      end

      // armed: a sync was seen and no beat has been emitted since
      armed_d = armed_q | sync_now;
      if (emit) begin
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q         <= MODE_BYPASS;
         parity_q       <= '0;
         armed_q        <= 1'b0;
         err_chn        <= 1'b0;
         s1_emit_q      <= 1'b0;
         s1_sync_q      <= 1'b0;
         s1_chn_q       <= '0;
         bus.dout_valid <= 1'b0;
         bus.sync_out   <= 1'b0;
         bus.dout_chn   <= '0;
      end else begin
         if (sync_now) begin
            mode_q <= mode_e'(cfg_mode);
         end
         parity_q <= parity_d;
         armed_q  <= armed_d;
         if (bus.din_valid && !chn_ok) begin
            err_chn <= 1'b1;
         end
         s1_emit_q <= emit;
         s1_sync_q <= armed_q | sync_now;
         if (emit) begin
            s1_chn_q <= bus.din_chn;
         end
         bus.dout_valid <= s1_emit_q;
         bus.sync_out   <= s1_emit_q && s1_sync_q;
         if (s1_emit_q) begin
            bus.dout_chn <= s1_chn_q;
         end
      end
   end

   for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
      prach_reshape2_lane #(
         .WIDTH   (WIDTH),
         .NUM_CHN (NUM_CHN),
         .CHN_W   (CHN_W)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .buf_wr    (buf_wr),
         .pair_rd   (pair_rd),
         .beat_load (emit),
         .out_load  (s1_emit_q),
         .chn_idx   (chn_idx),
         .din_dr    (bus.din_dr[l]),
         .din_di    (bus.din_di[l]),
         .p1_dr     (p1_dr[l]),
         .p1_di     (p1_di[l]),
         .p2_dr     (p2_dr[l]),
         .p2_di     (p2_di[l])
      );
   end

   assign bus.dout_p1_dr = p1_dr;
   assign bus.dout_p1_di = p1_di;
   assign bus.dout_p2_dr = p2_dr;
   assign bus.dout_p2_di = p2_di;

endmodule

// File: tb/tb_prach_reshape2.sv
// -----------------------------------------------------------------------------
// tb_prach_reshape2
// Directed frames plus randomized traffic against a behavioural model that
// keeps, per channel, an optional pending even sample and schedules every
// expected output beat at (drive cycle + 2).
// -----------------------------------------------------------------------------
module tb_prach_reshape2;

   localparam int NL = 3;
   localparam int W  = 16;
   localparam int NC = 8;
   localparam int DW = NL * W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_mode = 1'b0;
   logic err_chn;

   prach_reshape2_if #(.NUM_LANE(NL), .WIDTH(W)) bus ();

   prach_reshape2 #(
      .NUM_LANE (NL),
      .WIDTH    (W),
      .NUM_CHN  (NC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_mode (cfg_mode),
      .bus      (bus),
      .err_chn  (err_chn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] p1dr;
      logic [DW-1:0] p1di;
      logic [DW-1:0] p2dr;
      logic [DW-1:0] p2di;
      logic [7:0]    chn;
      bit            sync;
   } exp_t;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   exp_t exp_q [int];
   exp_t last;

   bit            m_mode;
   bit            m_armed;
   bit            m_err;
   bit            pend_v  [NC];
   logic [DW-1:0] pend_dr [NC];
   logic [DW-1:0] pend_di [NC];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rnd_vec();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] lane0_vec(input int v);
      logic [DW-1:0] r;
      r = rnd_vec();
      r[W-1:0] = W'(v);
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NC; i++) pend_v[i] = 1'b0;
      m_mode  = 1'b0;
      m_armed = 1'b0;
      m_err   = 1'b0;
      exp_q.delete();
      last = '{default: 0};
   endtask

   // One cycle of stimulus; the model decides what the DUT must emit 2 cycles on.
   task automatic drive(input bit v, input int chn, input bit s, input bit m,
                        input logic [DW-1:0] dr, input logic [DW-1:0] di);
      exp_t e;
      @(posedge clk);
      #1;
      bus.din_valid = v;
      bus.din_chn   = 8'(chn);
      bus.sync_in   = s;
      bus.din_dr    = dr;
      bus.din_di    = di;
      cfg_mode      = m;
      if (!v) return;
      if (s) begin
         for (int i = 0; i < NC; i++) pend_v[i] = 1'b0;
         m_mode  = m;
         m_armed = 1'b1;
      end
      if (chn >= NC) begin
         m_err = 1'b1;
         return;
      end
      if (m_mode && !pend_v[chn]) begin
         pend_v[chn]  = 1'b1;
         pend_dr[chn] = dr;
         pend_di[chn] = di;
         return;
      end
      if (m_mode) begin
         e.p1dr = pend_dr[chn];
         e.p1di = pend_di[chn];
         e.p2dr = dr;
         e.p2di = di;
         pend_v[chn] = 1'b0;
      end else begin
         e.p1dr = dr;
         e.p1di = di;
         e.p2dr = '0;
         e.p2di = '0;
      end
      e.chn  = 8'(chn);
      e.sync = m_armed;
      m_armed = 1'b0;
      exp_q[cyc + 2] = e;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0, cfg_mode, '0, '0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      chk_en        = 1'b0;
      rst_n         = 1'b0;
      bus.din_valid = 1'b0;
      bus.sync_in   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst dout_valid", bus.dout_valid, 0);
      check("rst sync_out", bus.sync_out, 0);
      check("rst err_chn", err_chn, 0);
      check("rst p1_dr", bus.dout_p1_dr, 0);
      check("rst p2_di", bus.dout_p2_di, 0);
      check("rst dout_chn", bus.dout_chn, 0);
      rst_n = 1'b1;
      model_clear();
      chk_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (exp_q.exists(cyc)) begin
            check("dout_valid", bus.dout_valid, 1);
            check("sync_out", bus.sync_out, 64'(exp_q[cyc].sync));
            check("dout_chn", bus.dout_chn, exp_q[cyc].chn);
            check("p1_dr", bus.dout_p1_dr, exp_q[cyc].p1dr);
            check("p1_di", bus.dout_p1_di, exp_q[cyc].p1di);
            check("p2_dr", bus.dout_p2_dr, exp_q[cyc].p2dr);
            check("p2_di", bus.dout_p2_di, exp_q[cyc].p2di);
            last = exp_q[cyc];
            exp_q.delete(cyc);
         end else begin
            check("idle dout_valid", bus.dout_valid, 0);
            check("idle sync_out", bus.sync_out, 0);
            check("hold dout_chn", bus.dout_chn, last.chn);
            check("hold p1_dr", bus.dout_p1_dr, last.p1dr);
            check("hold p2_di", bus.dout_p2_di, last.p2di);
         end
      end
   end

   initial begin
      bus.din_valid = 1'b0;
      bus.din_chn   = '0;
      bus.sync_in   = 1'b0;
      bus.din_dr    = '0;
      bus.din_di    = '0;
      model_clear();
      do_reset();

      // BYPASS frame, lane 0 carries chn*16
      for (int c = 0; c < NC; c++) drive(1'b1, c, c == 0, 1'b0, lane0_vec(c * 16), rnd_vec());
      idle(4);

      // PAIR, two rounds
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NC; c++)
            drive(1'b1, c, (r == 0) && (c == 0), 1'b1, lane0_vec(32'h100 * (r + 1) + c), rnd_vec());
      idle(4);

      // PAIR, sync re-asserted at chn 3 of round 1, then a completing round
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < NC; c++)
            drive(1'b1, c, (r == 0 && c == 0) || (r == 1 && c == 3), 1'b1, rnd_vec(), rnd_vec());
      idle(4);

      // out-of-range channel: dropped, sticky error
      drive(1'b1, 9, 1'b0, 1'b1, rnd_vec(), rnd_vec());
      idle(3);
      check("err_chn set", err_chn, 64'(m_err));
      for (int c = 0; c < NC; c++) drive(1'b1, c, 1'b0, 1'b1, rnd_vec(), rnd_vec());
      idle(3);
      check("err_chn sticky", err_chn, 1);

      // cfg_mode toggling without sync has no effect
      drive(1'b1, 0, 1'b1, 1'b1, rnd_vec(), rnd_vec());
      for (int i = 0; i < 3 * NC; i++)
         drive(1'b1, i % NC, 1'b0, i[0], rnd_vec(), rnd_vec());
      idle(3);

      // reset during round 1 of PAIR
      for (int c = 0; c < NC; c++) drive(1'b1, c, c == 0, 1'b1, rnd_vec(), rnd_vec());
      for (int c = 0; c < 4; c++) drive(1'b1, c, 1'b0, 1'b1, rnd_vec(), rnd_vec());
      do_reset();
      drive(1'b1, 2, 1'b0, 1'b1, rnd_vec(), rnd_vec());
      drive(1'b1, 2, 1'b1, 1'b1, rnd_vec(), rnd_vec());
      drive(1'b1, 2, 1'b0, 1'b0, rnd_vec(), rnd_vec());
      idle(4);

      // gapped PAIR traffic, 1 beat in 3 cycles
      drive(1'b1, 0, 1'b1, 1'b1, rnd_vec(), rnd_vec());
      for (int i = 0; i < 80; i++) begin
         idle(2);
         drive(1'b1, $urandom_range(0, NC - 1), 1'b0, 1'b1, rnd_vec(), rnd_vec());
      end
      idle(4);

      // fully random traffic
      for (int i = 0; i < 600; i++) begin
         bit v, s, m;
         int chn;
         v   = ($urandom_range(0, 3) != 0);
         s   = ($urandom_range(0, 15) == 0);
         m   = 1'($urandom_range(0, 1));
         chn = ($urandom_range(0, 31) == 0) ? $urandom_range(NC, 255) : $urandom_range(0, NC - 1);
         drive(v, chn, s, m, rnd_vec(), rnd_vec());
      end
      idle(5);
      check("err_chn final", err_chn, 64'(m_err));
      check("all expected beats seen", 64'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
